mem_port_arbiter: RTL and testbench

Sequencer that shares a single-port unified memory between the pipelined core's instruction-fetch stage and its data-memory stage. It arbitrates the two requesters, drives the memory handshake, and returns read data. It also generates stall requests that feed the hazard unit, so variable-latency memory is absorbed without corrupting pipeline state. Data accesses have priority; fetch responses invalidated by a taken branch are discarded.

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages, data first; MEMARB_TIMEOUT_EN adds a per-transaction watchdog
module mem_port_arbiter #(
  parameter int XLEN = 32
`ifdef MEMARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [XLEN/8-1:0] dm_wmask,
  input  logic [XLEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err_timeout
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2;
  logic [1:0] state, nextState;
  logic ifDone, dmDone, discard, done, timedOut, arb, grant, dmCand, ifCand;
`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] waitCnt;
  logic errFlag;
  assign timedOut = state != IDLE && !mem_ready && waitCnt == CW'(TIMEOUT - 1);
  assign err_timeout = errFlag;
  // wait counter restarts with every new transaction; timeout flag is sticky
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt <= '0;
      errFlag <= 1'b0;
    end else begin
      waitCnt <= (state == IDLE || done) ? '0 : waitCnt + 1'b1;
      errFlag <= errFlag | timedOut;
    end
  end
`else
  assign timedOut = 1'b0;
  assign err_timeout = 1'b0;
`endif
  assign done = state != IDLE && (mem_ready || timedOut);
  assign arb = state == IDLE || done;
  // a requester being served or just completed is masked since its req is still high
  assign dmCand = dm_req && !dmDone && state != DATA;
  assign ifCand = if_req && !ifDone && !flush && state != FETCH;
  assign grant = arb && nextState != IDLE;
  assign if_valid = ifDone && !flush;
  assign dm_valid = dmDone;
  assign stall_if = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;
  // arbitrate when idle or on completion so back-to-back accesses need no bubble
  always_comb nextState = arb ? (dmCand ? DATA : ifCand ? FETCH : IDLE) : state;
  // state, command capture, response capture and fetch discard tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_wmask <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ifDone <= 1'b0;
      dmDone <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      discard <= 1'b0;
    end else begin
      state <= nextState;
      mem_req <= nextState != IDLE;
      if (grant) begin
        mem_we <= nextState == DATA && dm_we;
        mem_wmask <= nextState == DATA ? dm_wmask : '0;
        mem_addr <= nextState == DATA ? dm_addr : if_addr;
        mem_wdata <= nextState == DATA ? dm_wdata : '0;
      end
      ifDone <= done && state == FETCH && !discard && !flush;
      dmDone <= done && state == DATA;
      if (done && state == FETCH) if_rdata <= timedOut ? '0 : mem_rdata;
      if (done && state == DATA) dm_rdata <= timedOut ? '0 : mem_rdata;
      discard <= state == FETCH && !done && (discard || flush);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (MEMARB_TIMEOUT_EN enables the watchdog case)
module tb_mem_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, dm_req = 0, dm_we = 0, flush = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0] dm_wmask = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem, err_timeout;
  typedef struct {bit isData; bit chk; logic [31:0] data; int cyc;} expEntry;
  expEntry sb[$];
  logic [31:0] memData [logic [31:0]];
  int memWait [logic [31:0]];
  int cyc = 0, nVec = 0, nErr = 0;

  mem_port_arbiter #(.XLEN(32)
`ifdef MEMARB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .dm_req(dm_req), .dm_we(dm_we), .dm_wmask(dm_wmask),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall_if(stall_if), .stall_mem(stall_mem),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: each address has its own wait count and contents
  initial forever begin
    int waitCnt;
    @(negedge clk);
    if (mem_req && waitCnt >= (memWait.exists(mem_addr) ? memWait[mem_addr] : 0)) begin
      mem_ready = 1;
      mem_rdata = memData.exists(mem_addr) ? memData[mem_addr] : 32'hFFFF_FFFF;
      waitCnt = 0;
    end else begin
      mem_ready = 0;
      mem_rdata = 32'hDEAD_DEAD;
      waitCnt = mem_req ? waitCnt + 1 : 0;
    end
  end

  task automatic score(input bit isData, input logic [31:0] data);
    expEntry e;
    nVec++;
    if (sb.size() == 0) begin
      nErr++;
      $display("FAIL unexpected_%s_valid: got data %h at cycle %0d, required no response", isData ? "dm" : "if", data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.isData != isData || e.cyc != cyc || (e.chk && data !== e.data)) begin
        nErr++;
        $display("FAIL response: got %s data %h cycle %0d, required %s data %h cycle %0d",
                 isData ? "dm" : "if", data, cyc, e.isData ? "dm" : "if", e.data, e.cyc);
      end
    end
  endtask

  // monitor: every valid pulse is matched against the oldest expectation
  initial forever begin
    @(negedge clk);
    if (dm_valid) score(1, dm_rdata);
    if (if_valid) score(0, if_rdata);
  end

  task automatic push(input bit isData, input logic [31:0] data, input bit chk, input int c);
    expEntry e;
    e.isData = isData;
    e.data = data;
    e.chk = chk;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic waitDrop(input bit isData);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = isData ? dm_valid : if_valid;
    end
    if (!seen) begin
      nVec++;
      nErr++;
      $display("FAIL %s_wait_timeout: got no valid in 40 cycles, required a valid", isData ? "dm" : "if");
    end
    @(posedge clk);
    #1;
    if (isData) dm_req = 0; else if_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    memData[32'h100] = 32'h0050_0093;  memWait[32'h100] = 0;
    memData[32'h104] = 32'h00A0_0113;  memWait[32'h104] = 2;
    memData[32'h108] = 32'hBADB_AD00;  memWait[32'h108] = 3;
    memData[32'h200] = 32'h0000_0297;  memWait[32'h200] = 0;
    memData[32'h300] = 32'h1111_2222;  memWait[32'h300] = 0;
    memData[32'h40]  = 32'h5555_AAAA;  memWait[32'h40]  = 1;
    memData[32'h2000] = 32'hCAFE_F00D; memWait[32'h2000] = 2;
    memData[32'h3000] = 32'h3333_4444; memWait[32'h3000] = 5;
    memData[32'h4000] = 32'h7777_7777; memWait[32'h4000] = 1000;
    idle(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_valids", {if_valid, dm_valid}, 0);
    check("rst_cmd", {mem_we, mem_wmask, mem_addr, mem_wdata}, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1;
    idle(2);
    // zero-wait fetch
    @(negedge clk); c = cyc;
    if_req = 1; if_addr = 32'h100;
    push(0, 32'h0050_0093, 1, c + 2);
    #1 check("stall_if_c0", stall_if, 1);
    @(negedge clk);
    check("stall_if_c1", stall_if, 1);
    check("mem_req_c1", mem_req, 1);
    check("mem_addr_c1", mem_addr, 32'h100);
    @(negedge clk);
    check("stall_if_c2", stall_if, 0);
    @(posedge clk); #1 if_req = 0;
    idle(3);
    // simultaneous requests: data first, fetch follows with no bubble
    @(negedge clk); c = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    if_req = 1; if_addr = 32'h104;
    push(1, 32'hCAFE_F00D, 1, c + 4);
    push(0, 32'h00A0_0113, 1, c + 7);
    fork
      waitDrop(1);
      waitDrop(0);
      begin
        repeat (4) @(negedge clk);
        check("b2b_fetch_mem_req", {mem_req, mem_addr}, {1'b1, 32'h104});
      end
    join
    idle(3);
    // store command held until ready
    @(negedge clk); c = cyc;
    dm_req = 1; dm_we = 1; dm_wmask = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    push(1, 32'h0, 0, c + 3);
    fork
      waitDrop(1);
      begin
        @(negedge clk);
        check("store_cmd_c1", {mem_req, mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF});
        @(negedge clk);
        check("store_cmd_c2", {mem_req, mem_we, mem_wmask, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF});
      end
    join
    dm_we = 0; dm_wmask = 0; dm_wdata = 0;
    idle(3);
    // flush during a waiting fetch discards it; redirected fetch returns
    @(negedge clk); c = cyc;
    if_req = 1; if_addr = 32'h108;
    push(0, 32'h0000_0297, 1, c + 7);
    idle(2);
    flush = 1; if_addr = 32'h200;
    @(negedge clk); flush = 0;
    waitDrop(0);
    idle(3);
    // flush in idle delays the fetch grant by one cycle
    @(negedge clk); c = cyc;
    if_req = 1; if_addr = 32'h100; flush = 1;
    push(0, 32'h0050_0093, 1, c + 3);
    @(negedge clk); flush = 0;
    waitDrop(0);
    idle(3);
    // flush coinciding with the valid pulse suppresses it
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    @(posedge clk); @(posedge clk); #1 flush = 1;
    @(negedge clk);
    check("if_valid_flushed", if_valid, 0);
    @(posedge clk); #1 flush = 0; if_req = 0;
    idle(3);
    // in-flight fetch is not preempted by a later load
    @(negedge clk); c = cyc;
    if_req = 1; if_addr = 32'h108;
    push(0, 32'hBADB_AD00, 1, c + 5);
    push(1, 32'hCAFE_F00D, 1, c + 8);
    fork
      waitDrop(0);
      begin
        @(negedge clk);
        dm_req = 1; dm_addr = 32'h2000;
        waitDrop(1);
      end
    join
    idle(3);
    // reset during a data wait abandons the access
    @(negedge clk);
    dm_req = 1; dm_addr = 32'h3000;
    idle(2);
    rst_n = 0;
    @(negedge clk);
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_dm_valid", dm_valid, 0);
    check("rst_mid_rdata", if_rdata | dm_rdata, 0);
    check("rst_mid_addr", mem_addr, 0);
    dm_req = 0; rst_n = 1;
    idle(2);
    @(negedge clk); c = cyc;
    dm_req = 1; dm_addr = 32'h300;
    push(1, 32'h1111_2222, 1, c + 2);
    waitDrop(1);
    idle(3);
`ifdef MEMARB_TIMEOUT_EN
    // memory never answers: watchdog completes the load with zero data
    @(negedge clk); c = cyc;
    dm_req = 1; dm_addr = 32'h4000;
    push(1, 32'h0, 1, c + 5);
    repeat (5) @(negedge clk);
    check("timeout_mem_req", mem_req, 0);
    check("timeout_err", err_timeout, 1);
    @(posedge clk); #1 dm_req = 0;
    idle(3);
    check("timeout_err_sticky", err_timeout, 1);
    rst_n = 0;
    @(negedge clk);
    check("timeout_err_rst", err_timeout, 0);
    rst_n = 1;
`else
    check("err_timeout_tied", err_timeout, 0);
`endif
    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
